// File: rtl/exec_seq_pkg.sv
// Shared types and defaults for the run/step/halt execution sequencer.
package exec_seq_pkg;

  localparam int unsigned SEQ_CNT_W = 16;

  // DONE has no code of its own: it is HALT plus the registered done flag.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } seq_state_t;

endpackage

// File: rtl/btn_pend.sv
// Button rising-edge detector with a sticky pending flag, cleared when consumed.
module btn_pend (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic consume,
  output logic pend
);

  logic prev_q;
  logic pend_q;
  logic rise;

  assign rise = btn & ~prev_q;
  // An edge arriving on the consuming cycle is acted on in that same slot.
  assign pend = pend_q | rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      prev_q <= btn;
      if (consume)   pend_q <= 1'b0;
      else if (rise) pend_q <= 1'b1;
    end
  end

endmodule

// File: rtl/exec_sequencer.sv
// Run/step/halt controller for the single-cycle core; issues pc_en/commit_en on divider ticks.
// Optional breakpoint support is enabled by defining EXEC_SEQ_BREAKPOINT_EN.
module exec_sequencer
  import exec_seq_pkg::*;
#(
  parameter int unsigned PC_W    = 10,
  parameter int unsigned PC_LAST = 52,
  parameter int unsigned CNT_W   = SEQ_CNT_W
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             tick,
  input  logic             run_btn,
  input  logic             step_btn,
  input  logic             halt_btn,
  input  logic [PC_W-1:0]  pc,
`ifdef EXEC_SEQ_BREAKPOINT_EN
  input  logic [PC_W-1:0]  bp_addr,
  input  logic             bp_valid,
  output logic             bp_hit,
`endif
  output logic             pc_en,
  output logic             commit_en,
  output logic [1:0]       state,
  output logic             done,
  output logic [CNT_W-1:0] retired
);

  logic run_pend, step_pend, halt_pend;

  btn_pend u_run  (.clk(clk_in), .rst(rst), .btn(run_btn),  .consume(tick), .pend(run_pend));
  btn_pend u_step (.clk(clk_in), .rst(rst), .btn(step_btn), .consume(tick), .pend(step_pend));
  btn_pend u_halt (.clk(clk_in), .rst(rst), .btn(halt_btn), .consume(tick), .pend(halt_pend));

  seq_state_t       state_q, state_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] retired_q;
  logic             issue;
  logic             at_last;

  assign at_last = (pc == PC_W'(PC_LAST));

`ifdef EXEC_SEQ_BREAKPOINT_EN
  logic bp_hit_q, bp_hit_d;
  logic bp_skip_q, bp_skip_d;
  logic bp_match;

  // bp_skip lets the first slot after a resume advance past the breakpoint.
  assign bp_match = bp_valid & (pc == bp_addr) & ~bp_skip_q;
  assign bp_hit   = bp_hit_q;
`endif

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    issue   = 1'b0;
`ifdef EXEC_SEQ_BREAKPOINT_EN
    bp_hit_d  = bp_hit_q;
    bp_skip_d = bp_skip_q;
`endif
    if (tick && !done_q) begin
      case (state_q)
        IDLE, HALT: begin
          if (halt_pend) begin
            state_d = HALT;
          end else if (step_pend || run_pend) begin
            state_d = step_pend ? STEP : RUN;
`ifdef EXEC_SEQ_BREAKPOINT_EN
            bp_hit_d  = 1'b0;
            bp_skip_d = bp_hit_q;
`endif
          end
        end
        RUN: begin
          if (halt_pend) state_d = HALT;
`ifdef EXEC_SEQ_BREAKPOINT_EN
          else if (bp_match) begin
            state_d  = HALT;
            bp_hit_d = 1'b1;
          end
`endif
          else issue = 1'b1;
        end
        STEP: begin
          state_d = HALT;
          if (!halt_pend) issue = 1'b1;
        end
        default: state_d = IDLE;
      endcase
      if (issue && at_last) begin
        state_d = HALT;
        done_d  = 1'b1;
      end
`ifdef EXEC_SEQ_BREAKPOINT_EN
      if (issue) bp_skip_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      retired_q <= '0;
`ifdef EXEC_SEQ_BREAKPOINT_EN
      bp_hit_q  <= 1'b0;
      bp_skip_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (issue && retired_q != '1) retired_q <= retired_q + CNT_W'(1);
`ifdef EXEC_SEQ_BREAKPOINT_EN
      bp_hit_q  <= bp_hit_d;
      bp_skip_q <= bp_skip_d;
`endif
    end
  end

  // Reset wins over a same-cycle tick, so no advance is presented to the core.
  assign pc_en     = issue & ~rst;
  assign commit_en = pc_en;
  assign state     = state_q;
  assign done      = done_q;
  assign retired   = retired_q;

endmodule
